// File: rtl/block_sched.sv
// rtl/block_sched.sv - column-block scheduler with partner-lane work stealing
//
// Hands out valid feature-map blocks to NUM_BLOCK_W lanes, one block per lane
// at a time. A lane whose own column is drained helps its partner lane
// (c + NUM_BLOCK_W/2) mod NUM_BLOCK_W by taking that column's highest pending
// row, but only while the partner still has two or more blocks pending.
//
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   clk_en       global stall; all registers hold while low
//   start        frame start (IDLE only); valid is captured with it
//   valid        block-valid map, bit c*NUM_BLOCK_H+r = column c, row r
//   lane_rdy     per-lane accept
//   blk_done     per-lane retire pulse
//   issue_vld    per-lane issue pulse
//   issue_row    per-lane issued row, slice [c*ROW_W +: ROW_W]
//   issue_col    per-lane source column, slice [c*COL_W +: COL_W]
//   issue_help   per-lane help select, held until the lane's next issue
//   lane_busy    per-lane unretired block
//   sched_busy   scheduler not IDLE
//   frame_done   pulse in the first IDLE cycle after a frame

module block_sched #(
   parameter int NUM_BLOCK_W = 4,
   parameter int NUM_BLOCK_H = 4,
   parameter int NUM_BLOCK   = NUM_BLOCK_W * NUM_BLOCK_H,
   parameter int ROW_W       = (NUM_BLOCK_H > 1) ? $clog2(NUM_BLOCK_H) : 1,
   parameter int COL_W       = (NUM_BLOCK_W > 1) ? $clog2(NUM_BLOCK_W) : 1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         clk_en,
   input  logic                         start,
   input  logic [NUM_BLOCK-1:0]         valid,
   input  logic [NUM_BLOCK_W-1:0]       lane_rdy,
   input  logic [NUM_BLOCK_W-1:0]       blk_done,
   output logic [NUM_BLOCK_W-1:0]       issue_vld,
   output logic [NUM_BLOCK_W*ROW_W-1:0] issue_row,
   output logic [NUM_BLOCK_W*COL_W-1:0] issue_col,
   output logic [NUM_BLOCK_W-1:0]       issue_help,
   output logic [NUM_BLOCK_W-1:0]       lane_busy,
   output logic                         sched_busy,
   output logic                         frame_done
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t                         state, state_nxt;
   logic [NUM_BLOCK-1:0]           pend;
   logic [NUM_BLOCK-1:0]           clr_mask;
   logic [NUM_BLOCK_W-1:0]         iss;
   logic [NUM_BLOCK_W*ROW_W-1:0]   row_nxt;
   logic [NUM_BLOCK_W*COL_W-1:0]   col_nxt;
   logic [NUM_BLOCK_W-1:0]         help_nxt;

   function automatic int partner(input int c);
      return (c + NUM_BLOCK_W / 2) % NUM_BLOCK_W;
   endfunction

   // Descending scan so the last hit is the lowest set row.
   function automatic int lowest_set(input logic [NUM_BLOCK_H-1:0] s);
      int r;
      r = 0;
      for (int i = NUM_BLOCK_H - 1; i >= 0; i--)
         if (s[i]) r = i;
      return r;
   endfunction

   function automatic int highest_set(input logic [NUM_BLOCK_H-1:0] s);
      int r;
      r = 0;
      for (int i = 0; i < NUM_BLOCK_H; i++)
         if (s[i]) r = i;
      return r;
   endfunction

   function automatic int pop_count(input logic [NUM_BLOCK_H-1:0] s);
      int n;
      n = 0;
      for (int i = 0; i < NUM_BLOCK_H; i++)
         if (s[i]) n++;
      return n;
   endfunction

   // Issue selection. The owner takes its lowest row; the helper only acts on
   // an empty own slice and takes the partner's highest row with at least two
   // pending, so owner and helper can never pick the same block.
   always_comb begin
      clr_mask = '0;
      iss      = '0;
      row_nxt  = issue_row;
      col_nxt  = issue_col;
      help_nxt = issue_help;
      if (state == RUN) begin
         for (int c = 0; c < NUM_BLOCK_W; c++) begin
            if (!lane_busy[c] && lane_rdy[c]) begin
               if (pend[c*NUM_BLOCK_H +: NUM_BLOCK_H] != '0) begin
                  iss[c] = 1'b1;
                  row_nxt[c*ROW_W +: ROW_W] =
                     ROW_W'(lowest_set(pend[c*NUM_BLOCK_H +: NUM_BLOCK_H]));
                  col_nxt[c*COL_W +: COL_W] = COL_W'(c);
                  help_nxt[c] = 1'b0;
                  clr_mask = clr_mask | (NUM_BLOCK'(1) << (c*NUM_BLOCK_H +
                     lowest_set(pend[c*NUM_BLOCK_H +: NUM_BLOCK_H])));
               end else if (pop_count(pend[partner(c)*NUM_BLOCK_H +: NUM_BLOCK_H]) >= 2) begin
                  iss[c] = 1'b1;
                  row_nxt[c*ROW_W +: ROW_W] =
                     ROW_W'(highest_set(pend[partner(c)*NUM_BLOCK_H +: NUM_BLOCK_H]));
                  col_nxt[c*COL_W +: COL_W] = COL_W'(partner(c));
                  help_nxt[c] = 1'b1;
                  clr_mask = clr_mask | (NUM_BLOCK'(1) << (partner(c)*NUM_BLOCK_H +
                     highest_set(pend[partner(c)*NUM_BLOCK_H +: NUM_BLOCK_H])));
               end
            end
         end
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (start) state_nxt = RUN;
         RUN:  if (pend == '0 && lane_busy == '0 && iss == '0) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         pend       <= '0;
         lane_busy  <= '0;
         issue_vld  <= '0;
         issue_row  <= '0;
         issue_col  <= '0;
         issue_help <= '0;
         frame_done <= 1'b0;
      end else if (clk_en) begin
         state      <= state_nxt;
         issue_vld  <= '0;
         frame_done <= 1'b0;
         if (state == IDLE) begin
            if (start) begin
               pend       <= valid;
               lane_busy  <= '0;
               issue_help <= '0;
            end
         end else begin
            pend       <= pend & ~clr_mask;
            // Retire only affects busy lanes; issue only targets idle lanes.
            lane_busy  <= (lane_busy & ~blk_done) | iss;
            issue_vld  <= iss;
            issue_row  <= row_nxt;
            issue_col  <= col_nxt;
            issue_help <= help_nxt;
            if (state_nxt == IDLE) frame_done <= 1'b1;
         end
      end
   end

   assign sched_busy = (state != IDLE);

endmodule

// File: tb/tb_block_sched.sv
// tb/tb_block_sched.sv - directed self-checking bench for block_sched

module tb_block_sched;

   logic        clk;
   logic        rst_n;
   logic        clk_en;
   logic        start;
   logic [15:0] valid;
   logic [3:0]  lane_rdy;
   logic [3:0]  blk_done;
   logic [3:0]  issue_vld;
   logic [7:0]  issue_row;
   logic [7:0]  issue_col;
   logic [3:0]  issue_help;
   logic [3:0]  lane_busy;
   logic        sched_busy;
   logic        frame_done;

   int n_assert = 0;
   int n_fail   = 0;
   int n_iss;
   int n_fd;

   block_sched dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .clk_en     (clk_en),
      .start      (start),
      .valid      (valid),
      .lane_rdy   (lane_rdy),
      .blk_done   (blk_done),
      .issue_vld  (issue_vld),
      .issue_row  (issue_row),
      .issue_col  (issue_col),
      .issue_help (issue_help),
      .lane_busy  (lane_busy),
      .sched_busy (sched_busy),
      .frame_done (frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
      blk_done = '0;
      start    = 1'b0;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst_n    = 1'b0;
      clk_en   = 1'b1;
      start    = 1'b0;
      valid    = '0;
      lane_rdy = 4'hF;
      blk_done = '0;
      tick();
      tick();
      chk("reset_outs", 32'({issue_vld, issue_row, issue_col, issue_help,
                             lane_busy, sched_busy, frame_done}), 0);
      rst_n = 1'b1;
      tick();

      // Plain frame: rows 2 and 3 in every lane, retire 3 cycles after issue
      valid = 16'hCCCC;
      start = 1'b1;
      tick();
      n_iss = 0;
      n_fd  = 0;
      for (int cyc = 1; cyc <= 13; cyc++) begin
         chk("plain_vld", 32'(issue_vld), (cyc == 2 || cyc == 7) ? 'hF : 0);
         chk("plain_help", 32'(issue_help), 0);
         chk("plain_done", 32'(frame_done), 32'(cyc == 12));
         chk("plain_busy", 32'(sched_busy), 32'(cyc < 12));
         if (cyc == 2) chk("plain_row2", 32'(issue_row), 'hAA);
         if (cyc == 2) chk("plain_col", 32'(issue_col), 'hE4);
         if (cyc == 7) chk("plain_row3", 32'(issue_row), 'hFF);
         n_iss += $countones(issue_vld);
         if (frame_done) n_fd++;
         if (cyc == 5 || cyc == 10) blk_done = 4'hF;
         tick();
      end
      chk("plain_issues", n_iss, 8);
      chk("plain_fd_count", n_fd, 1);

      // Help: lane 0 = 0001, lane 2 = 1111
      valid = 16'h0F01;
      start = 1'b1;
      tick();                                          // c1
      chk("help_c1_vld", 32'(issue_vld), 0);
      tick();                                          // c2
      chk("help_c2_vld", 32'(issue_vld), 'b0101);
      chk("help_c2_row_l0", 32'(issue_row[1:0]), 0);
      chk("help_c2_row_l2", 32'(issue_row[5:4]), 0);
      chk("help_c2_col_l2", 32'(issue_col[5:4]), 2);
      chk("help_c2_help", 32'(issue_help), 0);
      tick();                                          // c3
      chk("help_c3_vld", 32'(issue_vld), 0);
      blk_done = 4'b0001;
      tick();                                          // c4
      chk("help_c4_busy", 32'(lane_busy), 'b0100);
      chk("help_c4_vld", 32'(issue_vld), 0);
      tick();                                          // c5
      chk("help_c5_vld", 32'(issue_vld), 'b0001);
      chk("help_c5_row_l0", 32'(issue_row[1:0]), 3);
      chk("help_c5_col_l0", 32'(issue_col[1:0]), 2);
      chk("help_c5_help", 32'(issue_help), 'b0001);
      blk_done = 4'b0100;
      tick();                                          // c6
      chk("help_c6_vld", 32'(issue_vld), 0);
      chk("help_c6_busy", 32'(lane_busy), 'b0001);
      tick();                                          // c7
      chk("help_c7_vld", 32'(issue_vld), 'b0100);
      chk("help_c7_row_l2", 32'(issue_row[5:4]), 1);
      chk("help_c7_help", 32'(issue_help), 'b0001);
      blk_done = 4'b0001;
      tick();                                          // c8
      chk("help_c8_busy", 32'(lane_busy), 'b0100);
      tick();                                          // c9
      chk("help_no_steal_last", 32'(issue_vld), 0);
      chk("help_c9_busy", 32'(lane_busy), 'b0100);
      blk_done = 4'b0100;
      tick();                                          // c10
      tick();                                          // c11
      chk("help_c11_vld", 32'(issue_vld), 'b0100);
      chk("help_c11_row_l2", 32'(issue_row[5:4]), 2);
      chk("help_c11_help", 32'(issue_help), 'b0001);
      blk_done = 4'b0100;
      tick();                                          // c12
      chk("help_c12_sched", 32'(sched_busy), 1);
      chk("help_c12_done", 32'(frame_done), 0);
      tick();                                          // c13
      chk("help_c13_done", 32'(frame_done), 1);
      chk("help_c13_sched", 32'(sched_busy), 0);

      // Empty frame
      valid = '0;
      start = 1'b1;
      tick();                                          // c1
      chk("empty_c1_sched", 32'(sched_busy), 1);
      chk("empty_c1_vld", 32'(issue_vld), 0);
      chk("empty_c1_done", 32'(frame_done), 0);
      tick();                                          // c2
      chk("empty_c2_done", 32'(frame_done), 1);
      chk("empty_c2_vld", 32'(issue_vld), 0);
      chk("empty_c2_sched", 32'(sched_busy), 0);
      tick();                                          // c3
      chk("empty_c3_done", 32'(frame_done), 0);

      // Backpressure, spurious retire, ignored start, clk_en stall
      valid    = 16'h0023;
      lane_rdy = 4'b1101;
      start    = 1'b1;
      tick();                                          // c1
      tick();                                          // c2
      chk("bp_c2_vld", 32'(issue_vld), 'b0101);
      chk("bp_c2_row_l0", 32'(issue_row[1:0]), 0);
      chk("bp_c2_col_l0", 32'(issue_col[1:0]), 0);
      chk("bp_c2_row_l2", 32'(issue_row[5:4]), 1);
      chk("bp_c2_col_l2", 32'(issue_col[5:4]), 0);
      chk("bp_c2_help", 32'(issue_help), 'b0100);
      blk_done = 4'b0101;
      tick();                                          // c3
      for (int cyc = 3; cyc <= 9; cyc++) begin
         chk("bp_hold_vld", 32'(issue_vld), 0);
         chk("bp_hold_busy", 32'(lane_busy), 0);
         chk("bp_hold_sched", 32'(sched_busy), 1);
         if (cyc == 4) blk_done = 4'b0100;
         if (cyc == 5) begin
            start = 1'b1;
            valid = 16'hFFFF;
         end
         tick();
      end
      lane_rdy = 4'hF;                                 // c10
      chk("bp_c10_vld", 32'(issue_vld), 0);
      tick();                                          // c11
      chk("bp_c11_vld", 32'(issue_vld), 'b0010);
      chk("bp_c11_row_l1", 32'(issue_row[3:2]), 1);
      chk("bp_c11_col_l1", 32'(issue_col[3:2]), 1);
      chk("bp_c11_help", 32'(issue_help), 'b0100);
      clk_en = 1'b0;
      for (int k = 0; k < 5; k++) begin
         if (k == 2) blk_done = 4'b0010;
         tick();
         chk("stall_vld", 32'(issue_vld), 'b0010);
         chk("stall_busy", 32'(lane_busy), 'b0010);
         chk("stall_sched", 32'(sched_busy), 1);
      end
      clk_en = 1'b1;
      tick();                                          // c17
      chk("bp_c17_vld", 32'(issue_vld), 0);
      chk("bp_c17_busy", 32'(lane_busy), 'b0010);
      blk_done = 4'b0010;
      tick();                                          // c18
      chk("bp_c18_busy", 32'(lane_busy), 0);
      chk("bp_c18_vld", 32'(issue_vld), 0);
      chk("bp_c18_done", 32'(frame_done), 0);
      tick();                                          // c19
      chk("bp_c19_done", 32'(frame_done), 1);

      // Simultaneous retire on all lanes, then reset mid-frame
      valid = 16'h3333;
      start = 1'b1;
      tick();                                          // c1
      tick();                                          // c2
      chk("sim_c2_vld", 32'(issue_vld), 'hF);
      chk("sim_c2_row", 32'(issue_row), 'h00);
      chk("sim_c2_col", 32'(issue_col), 'hE4);
      tick();                                          // c3
      tick();                                          // c4
      blk_done = 4'hF;
      tick();                                          // c5
      chk("sim_c5_vld", 32'(issue_vld), 0);
      chk("sim_c5_busy", 32'(lane_busy), 0);
      tick();                                          // c6
      chk("sim_c6_vld", 32'(issue_vld), 'hF);
      chk("sim_c6_row", 32'(issue_row), 'h55);
      rst_n = 1'b0;
      tick();                                          // c7
      rst_n = 1'b1;
      chk("midrst_outs", 32'({issue_vld, issue_row, issue_col, issue_help,
                              lane_busy, sched_busy, frame_done}), 0);

      // Fresh frame after reset: one block per lane, distinct rows
      valid = 16'h8421;
      start = 1'b1;
      tick();                                          // c1
      chk("post_c1_sched", 32'(sched_busy), 1);
      tick();                                          // c2
      chk("post_c2_vld", 32'(issue_vld), 'hF);
      chk("post_c2_row", 32'(issue_row), 'hE4);
      chk("post_c2_col", 32'(issue_col), 'hE4);
      chk("post_c2_help", 32'(issue_help), 0);
      tick();                                          // c3
      chk("post_c3_vld", 32'(issue_vld), 0);
      blk_done = 4'hF;
      tick();                                          // c4
      chk("post_c4_busy", 32'(lane_busy), 0);
      tick();                                          // c5
      chk("post_c5_done", 32'(frame_done), 1);
      chk("post_c5_vld", 32'(issue_vld), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
